// File: rtl/vu_meter_pkg.sv
// Shared types and constants for the stereo VU meter.
// Holds the channel state enum, the magnitude width, the decay shift and the saturating abs helper.
package vu_meter_pkg;

    localparam int unsigned SampleWidth = 16;
    localparam int unsigned MagWidth    = 15;
    localparam int unsigned LevelWidth  = 4;
    localparam int unsigned DecayShift  = 3;

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StDecay
    } ch_state_e;

    // -32768 has no 15-bit magnitude, so it saturates to full scale.
    function automatic logic [MagWidth-1:0] abs_sat(input logic [SampleWidth-1:0] s);
        logic [SampleWidth-1:0] neg;
        neg = ~s + SampleWidth'(1);
        if (!s[SampleWidth-1]) begin
            return s[MagWidth-1:0];
        end else if (s == {1'b1, {(SampleWidth-1){1'b0}}}) begin
            return '1;
        end else begin
            return neg[MagWidth-1:0];
        end
    endfunction

endpackage

// File: rtl/vu_channel.sv
// One meter channel: peak detect with hold and stepped decay, plus clip hold.
// State advances only on processed samples; clear forces the channel back to idle.
module vu_channel
    import vu_meter_pkg::*;
#(
    parameter int unsigned HOLD_SAMPLES  = 4800,
    parameter int unsigned DECAY_SAMPLES = 480
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   valid,
    input  logic [SampleWidth-1:0] sample,
    output logic [LevelWidth-1:0]  level,
    output logic                   clip_active
);

    localparam int unsigned HoldW  = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
    localparam int unsigned DecayW = (DECAY_SAMPLES > 1) ? $clog2(DECAY_SAMPLES) : 1;
    localparam logic [HoldW-1:0]  HoldLoad  = HoldW'(HOLD_SAMPLES - 1);
    localparam logic [DecayW-1:0] DecayLoad = DecayW'(DECAY_SAMPLES - 1);
    localparam logic [MagWidth-1:0] MinDecayPeak = MagWidth'(1 << DecayShift);

    ch_state_e            state_q, state_d;
    logic [MagWidth-1:0]  peak_q, peak_d;
    logic [HoldW-1:0]     hold_q, hold_d;
    logic [DecayW-1:0]    decay_q, decay_d;
    logic [HoldW-1:0]     clip_q, clip_d;
    logic [LevelWidth-1:0] level_q, level_d;

    logic [MagWidth-1:0] mag;
    logic                new_peak;
    logic                full_scale;
    logic                decay_step;
    logic                peak_small;

    assign mag        = abs_sat(sample);
    assign new_peak   = (mag > peak_q);
    assign full_scale = (mag == '1);
    assign decay_step = (state_q == StDecay) && (decay_q == '0);
    assign peak_small = (peak_q < MinDecayPeak);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = StIdle;
        end else if (valid) begin
            if (new_peak) begin
                state_d = StHold;
            end else begin
                unique case (state_q)
                    StIdle:  state_d = StIdle;
                    StHold:  if (hold_q == '0) state_d = StDecay;
                    StDecay: if (decay_step && peak_small) state_d = StIdle;
                    default: state_d = StIdle;
                endcase
            end
        end
    end

    // Peak, counters and level next values
    always_comb begin
        peak_d  = peak_q;
        hold_d  = hold_q;
        decay_d = decay_q;
        clip_d  = clip_q;
        if (clear) begin
            peak_d  = '0;
            hold_d  = '0;
            decay_d = '0;
            clip_d  = '0;
        end else if (valid) begin
            if (new_peak) begin
                peak_d = mag;
                hold_d = HoldLoad;
            end else if (state_q == StHold) begin
                if (hold_q == '0) begin
                    decay_d = DecayLoad;
                end else begin
                    hold_d = hold_q - HoldW'(1);
                end
            end else if (state_q == StDecay) begin
                if (decay_q == '0) begin
                    decay_d = DecayLoad;
                    // Below 8 the shift yields zero, so snap straight to silence.
                    peak_d  = peak_small ? '0 : (peak_q - (peak_q >> DecayShift));
                end else begin
                    decay_d = decay_q - DecayW'(1);
                end
            end
            if (full_scale) begin
                clip_d = HoldLoad;
            end else if (clip_q != '0) begin
                clip_d = clip_q - HoldW'(1);
            end
        end
        level_d = peak_d[MagWidth-1 -: LevelWidth];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            peak_q  <= '0;
            hold_q  <= '0;
            decay_q <= '0;
            clip_q  <= '0;
            level_q <= '0;
        end else begin
            peak_q  <= peak_d;
            hold_q  <= hold_d;
            decay_q <= decay_d;
            clip_q  <= clip_d;
            level_q <= level_d;
        end
    end

    // Outputs
    always_comb begin
        level       = level_q;
        clip_active = (clip_q != '0);
    end

endmodule

// File: rtl/vu_meter.sv
// Stereo VU meter top: registers the sample pair, then updates both channels a cycle later.
// level_valid marks the cycle the levels reflect a newly processed sample.
module vu_meter
    import vu_meter_pkg::*;
#(
    parameter int unsigned HOLD_SAMPLES  = 4800,
    parameter int unsigned DECAY_SAMPLES = 480
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   new_sample,
    input  logic [SampleWidth-1:0] sample_left,
    input  logic [SampleWidth-1:0] sample_right,
    output logic [LevelWidth-1:0]  level_left,
    output logic [LevelWidth-1:0]  level_right,
    output logic                   clip,
    output logic                   level_valid
);

    logic                   s1_valid_q;
    logic [SampleWidth-1:0] s1_left_q;
    logic [SampleWidth-1:0] s1_right_q;
    logic                   level_valid_q;
    logic                   proc_valid;
    logic                   clear;
    logic                   clip_left;
    logic                   clip_right;

    assign clear      = !enable;
    // Gating with enable drops a stage-1 sample if enable fell in between.
    assign proc_valid = s1_valid_q && enable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q    <= 1'b0;
            s1_left_q     <= '0;
            s1_right_q    <= '0;
            level_valid_q <= 1'b0;
        end else begin
            s1_valid_q    <= enable && new_sample;
            level_valid_q <= proc_valid;
            if (enable && new_sample) begin
                s1_left_q  <= sample_left;
                s1_right_q <= sample_right;
            end
        end
    end

    vu_channel #(
        .HOLD_SAMPLES  (HOLD_SAMPLES),
        .DECAY_SAMPLES (DECAY_SAMPLES)
    ) u_left (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .valid       (proc_valid),
        .sample      (s1_left_q),
        .level       (level_left),
        .clip_active (clip_left)
    );

    vu_channel #(
        .HOLD_SAMPLES  (HOLD_SAMPLES),
        .DECAY_SAMPLES (DECAY_SAMPLES)
    ) u_right (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .valid       (proc_valid),
        .sample      (s1_right_q),
        .level       (level_right),
        .clip_active (clip_right)
    );

    assign clip        = clip_left || clip_right;
    assign level_valid = level_valid_q;

endmodule
